tx_queue_arb: RTL and testbench

Multi-queue transmit scheduler placed in front of the MAC transmit block. Shares the single MAC frame interface (8-bit data FIFO read port plus 16-bit frame-pointer FIFO read port, length in pointer bits [10:0]) among N per-queue FIFO pairs. Arbitration uses strict priority or round robin, locked per frame. The MAC sees one ordinary FIFO pair and stays unaware of the queues.

---
 rtl/tx_queue_arb_pkg.sv | 11 +
 rtl/tx_queue_arb_if.sv | 25 ++
 rtl/tx_queue_arb_rr_pick.sv | 29 ++
 rtl/tx_queue_arb.sv | 96 +++++++++
 tb/tb_tx_queue_arb.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tx_queue_arb_pkg.sv
// Shared types and defaults for the multi-queue transmit scheduler.
package tx_arb_pkg;
  localparam int PTR_W_DEF = 16;
  localparam int LEN_W_DEF = 11;

  typedef enum logic [2:0] {IDLE, OFFER, LEN, BUSY, DRAIN} arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tx_queue_arb_if.sv
// Queue-side FIFO read ports plus the single MAC-facing FIFO pair.
interface tx_queue_arb_if import tx_arb_pkg::*; #(
  parameter int N     = 4,
  parameter int PTR_W = PTR_W_DEF
);
  logic [N-1:0]            q_ptr_empty;
  logic [N-1:0]            q_ptr_rd;
  logic [N-1:0][PTR_W-1:0] q_ptr_din;
  logic [N-1:0]            q_data_rd;
  logic [N-1:0][7:0]       q_data_din;
  logic                    ptr_fifo_empty;
  logic                    ptr_fifo_rd;
  logic [PTR_W-1:0]        ptr_fifo_din;
  logic                    data_fifo_rd;
  logic [7:0]              data_fifo_din;

  modport slave (
    input  q_ptr_empty, q_ptr_din, q_data_din, ptr_fifo_rd, data_fifo_rd,
    output q_ptr_rd, q_data_rd, ptr_fifo_empty, ptr_fifo_din, data_fifo_din
  );
  modport master (
    output q_ptr_empty, q_ptr_din, q_data_din, ptr_fifo_rd, data_fifo_rd,
    input  q_ptr_rd, q_data_rd, ptr_fifo_empty, ptr_fifo_din, data_fifo_din
  );
endinterface

// File: rtl/tx_queue_arb_rr_pick.sv
// Combinational rotating-priority picker; strict mode forces the search to start at 0.
module rr_pick import tx_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic          i_strict,
  output logic [IW-1:0] o_win,
  output logic          o_vld
);
  int w_base;
  int w_idx;

  always_comb begin
    o_win  = '0;
    o_vld  = 1'b0;
    w_idx  = 0;
    w_base = i_strict ? 0 : int'(i_start);
    for (int k = 0; k < N; k++) begin
      w_idx = w_base + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_vld && i_req[IW'(w_idx)]) begin
        o_vld = 1'b1;
        o_win = IW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/tx_queue_arb.sv
// Multiplexes N queue FIFO pairs onto one MAC FIFO pair, one locked frame at a time.
module tx_queue_arb import tx_arb_pkg::*; #(
  parameter int N     = 4,
  parameter int PTR_W = PTR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
)(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 prio_mode,
  input  logic [N-1:0]         q_en,
  tx_queue_arb_if.slave        bus,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 err_stray
);
  localparam int IW = idx_w(N);

  arb_state_e       r_state, w_state_nxt;
  logic [IW-1:0]    r_grant_id, r_last_grant, w_rr_start, w_pick;
  logic             r_grant_vld, r_err, w_pick_vld;
  logic [LEN_W-1:0] r_cnt, w_len;
  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     w_elig, w_q_ptr_rd, w_q_data_rd;

  assign w_elig     = ~bus.q_ptr_empty & q_en;
  assign w_rr_start = (r_last_grant == IW'(N-1)) ? '0 : r_last_grant + 1'b1;
  assign w_len      = bus.q_ptr_din[r_grant_id][LEN_W-1:0];

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req    (w_elig),
    .i_start  (w_rr_start),
    .i_strict (prio_mode),
    .o_win    (w_pick),
    .o_vld    (w_pick_vld)
  );

  // MAC strobes are forwarded only in their legal state and only to the locked queue.
  always_comb begin
    w_state_nxt = r_state;
    w_q_ptr_rd  = '0;
    w_q_data_rd = '0;
    unique case (r_state)
      IDLE:  if (w_pick_vld) w_state_nxt = OFFER;
      OFFER: if (bus.ptr_fifo_rd) begin
        w_q_ptr_rd[r_grant_id] = 1'b1;
        w_state_nxt = LEN;
      end
      LEN:   w_state_nxt = (w_len == '0) ? DRAIN : BUSY;
      BUSY:  if (bus.data_fifo_rd) begin
        w_q_data_rd[r_grant_id] = 1'b1;
        if (r_cnt == LEN_W'(1)) w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_grant_vld  <= 1'b0;
      r_last_grant <= IW'(N-1);
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_grant_id   <= w_pick;
          r_last_grant <= w_pick;
          r_grant_vld  <= 1'b1;
        end
        LEN: begin
          r_ptr <= bus.q_ptr_din[r_grant_id];
          r_cnt <= w_len;
        end
        BUSY:  if (bus.data_fifo_rd && r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
        DRAIN: r_grant_vld <= 1'b0;
        default: ;
      endcase
      if ((bus.ptr_fifo_rd && r_state != OFFER) || (bus.data_fifo_rd && r_state != BUSY))
        r_err <= 1'b1;
    end
  end

  assign bus.q_ptr_rd       = w_q_ptr_rd;
  assign bus.q_data_rd      = w_q_data_rd;
  assign bus.ptr_fifo_empty = (r_state != OFFER);
  assign bus.ptr_fifo_din   = r_ptr;
  assign bus.data_fifo_din  = bus.q_data_din[r_grant_id];
  assign grant_vld          = r_grant_vld;
  assign grant_id           = r_grant_id;
  assign err_stray          = r_err;
endmodule

// File: tb/tb_tx_queue_arb.sv
// Directed bench: queue FIFO models, a MAC-side frame reader and a per-queue pointer scoreboard.
module tb_tx_queue_arb;
  localparam int N = 4;

  logic clk = 1'b0, rstn = 1'b0, prio_mode = 1'b0;
  logic [N-1:0] q_en = '0;
  logic grant_vld, err_stray;
  logic [1:0] grant_id;
  logic ptr_fifo_rd = 1'b0, data_fifo_rd = 1'b0;

  logic [N-1:0]       qe  = '1;
  logic [N-1:0][15:0] pdo = '0;
  logic [N-1:0][7:0]  ddo = '0;
  logic [15:0] pq[N][$];
  logic [7:0]  dq[N][$];
  logic [15:0] sb[N][$];
  int prd[N];
  int drd[N];
  logic uf = 1'b0;
  logic ld_vld = 1'b0, flush = 1'b0;
  int ld_q = 0;
  logic [15:0] ld_ptr = '0;
  int checks = 0, errors = 0, tagc = 1;

  tx_queue_arb_if #(.N(N), .PTR_W(16)) bus();

  assign bus.q_ptr_empty  = qe;
  assign bus.q_ptr_din    = pdo;
  assign bus.q_data_din   = ddo;
  assign bus.ptr_fifo_rd  = ptr_fifo_rd;
  assign bus.data_fifo_rd = data_fifo_rd;

  tx_queue_arb #(.N(N), .PTR_W(16), .LEN_W(11)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .prio_mode (prio_mode),
    .q_en      (q_en),
    .bus       (bus),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bval(input int q, input logic [15:0] p, input int k);
    return 8'(q * 37 + int'(p[15:11]) * 11 + k);
  endfunction

  // Standard-read-mode queue FIFOs: output updates after the edge that sees rd.
  always @(posedge clk) begin
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) begin
      if (bus.q_ptr_rd[i]) begin
        if (pq[i].size() == 0) uf = 1'b1;
        else begin pdo[i] <= pq[i].pop_front(); prd[i]++; end
      end
      if (bus.q_data_rd[i]) begin
        if (dq[i].size() == 0) uf = 1'b1;
        else begin ddo[i] <= dq[i].pop_front(); drd[i]++; end
      end
      if (flush) begin pq[i].delete(); dq[i].delete(); end
    end
    if (ld_vld) begin
      pq[ld_q].push_back(ld_ptr);
      for (int k = 0; k < int'(ld_ptr[10:0]); k++) dq[ld_q].push_back(bval(ld_q, ld_ptr, k));
    end
    for (int i = 0; i < N; i++) e[i] = (pq[i].size() == 0);
    qe <= e;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int q, input int len);
    logic [15:0] p;
    p = {tagc[4:0], len[10:0]};
    tagc++;
    sb[q].push_back(p);
    ld_q = q; ld_ptr = p; ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0;
  endtask

  // Wait for an offer, read the pointer, pull every byte, then return in IDLE.
  task automatic mac_frame(input int eq);
    logic [15:0] ep;
    int len, n, d0, p0;
    ep = sb[eq].pop_front();
    len = int'(ep[10:0]);
    d0 = drd[eq]; p0 = prd[eq];
    n = 0;
    while (bus.ptr_fifo_empty && n < 100) begin @(negedge clk); n++; end
    chk("offer", 32'(bus.ptr_fifo_empty), 0);
    chk("grant_vld", 32'(grant_vld), 1);
    chk("grant_id", 32'(grant_id), eq);
    ptr_fifo_rd = 1'b1;
    @(negedge clk);
    ptr_fifo_rd = 1'b0;
    @(negedge clk);
    chk("ptr_capture", 32'(bus.ptr_fifo_din), 32'(ep));
    if (len > 0) begin
      data_fifo_rd = 1'b1;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        if (k == len - 1) data_fifo_rd = 1'b0;
        chk("byte", 32'(bus.data_fifo_din), 32'(bval(eq, ep, k)));
      end
    end
    @(negedge clk);
    chk("grant_clr", 32'(grant_vld), 0);
    chk("ptr_hold", 32'(bus.ptr_fifo_din), 32'(ep));
    chk("n_data_rd", 32'(drd[eq] - d0), 32'(len));
    chk("n_ptr_rd", 32'(prd[eq] - p0), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p2, d1;
    repeat (2) @(negedge clk);
    chk("rst_ptr_empty", 32'(bus.ptr_fifo_empty), 1);
    chk("rst_grant_vld", 32'(grant_vld), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err", 32'(err_stray), 0);
    chk("rst_ptr_din", 32'(bus.ptr_fifo_din), 0);
    chk("rst_q_rd", 32'({bus.q_ptr_rd, bus.q_data_rd}), 0);
    rstn = 1'b1;
    @(negedge clk);

    // single 60-byte frame on queue 0
    load(0, 60);
    q_en = 4'b1111;
    mac_frame(0);

    // round robin from reset: 0,1,2,3,0,1,2,3
    q_en = '0;
    rstn = 1'b0; @(negedge clk); rstn = 1'b1; @(negedge clk);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++) load(q, 3 + q + r);
    q_en = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++) mac_frame(q);

    // strict priority: queue 1 drains before queue 3
    q_en = '0; prio_mode = 1'b1;
    for (int r = 0; r < 3; r++) load(1, 2 + r);
    for (int r = 0; r < 2; r++) load(3, 4 + r);
    q_en = 4'b1111;
    mac_frame(1); mac_frame(1); mac_frame(1); mac_frame(3); mac_frame(3);

    // queue 2 masked for one round, then re-enabled
    q_en = '0; prio_mode = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++) load(q, 2 + q);
    p2 = prd[2];
    q_en = 4'b1011;
    mac_frame(0); mac_frame(1); mac_frame(3);
    chk("q2_masked", 32'(prd[2] - p2), 0);
    q_en = 4'b1111;
    mac_frame(0); mac_frame(1); mac_frame(2); mac_frame(3); mac_frame(2);

    // zero-length frame, then a stray data strobe in IDLE
    q_en = '0;
    load(0, 0);
    q_en = 4'b1111;
    mac_frame(0);
    chk("err_before", 32'(err_stray), 0);
    d1 = drd[0];
    data_fifo_rd = 1'b1;
    #1 chk("stray_fwd", 32'(bus.q_data_rd), 0);
    @(negedge clk);
    data_fifo_rd = 1'b0;
    chk("err_stray", 32'(err_stray), 1);
    chk("stray_cnt", 32'(drd[0] - d1), 0);
    repeat (2) @(negedge clk);
    chk("err_sticky", 32'(err_stray), 1);

    // reset in BUSY after 10 of 40 bytes
    load(1, 40);
    void'(sb[1].pop_front());
    d1 = drd[1];
    while (bus.ptr_fifo_empty) @(negedge clk);
    ptr_fifo_rd = 1'b1; @(negedge clk); ptr_fifo_rd = 1'b0; @(negedge clk);
    data_fifo_rd = 1'b1;
    repeat (10) @(negedge clk);
    data_fifo_rd = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(drd[1] - d1), 10);
    chk("mid_rst_ptr_empty", 32'(bus.ptr_fifo_empty), 1);
    chk("mid_rst_grant", 32'({grant_vld, grant_id}), 0);
    chk("mid_rst_err", 32'(err_stray), 0);
    chk("mid_rst_ptr_din", 32'(bus.ptr_fifo_din), 0);
    chk("mid_rst_q_rd", 32'({bus.q_ptr_rd, bus.q_data_rd}), 0);
    q_en = '0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; rstn = 1'b1;
    @(negedge clk);
    load(2, 5);
    q_en = 4'b1111;
    mac_frame(2);
    chk("no_underflow", 32'(uf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
